// File: rtl/layer_mac_scheduler_if.sv
// Handshake and memory-port bundle between the layer MAC scheduler and its
// activation/weight memories and result sink.
interface layer_mac_scheduler_if #(
    parameter int DW = 24
) ();
    // start is a one-cycle request and is only honoured while busy is low.
    // act_data/w_data answer the act_addr/w_addr presented with rd_en one cycle
    // earlier, and out_valid strobes each neuron result for exactly one cycle.
    logic          start;
    logic          busy;
    logic          done;
    logic [7:0]    act_addr;
    logic [DW-1:0] act_data;
    logic [15:0]   w_addr;
    logic [DW-1:0] w_data;
    logic          rd_en;
    logic          out_valid;
    logic [7:0]    out_idx;
    logic [7:0]    out_data;

    modport master (
        input  start, act_data, w_data,
        output busy, done, act_addr, w_addr, rd_en, out_valid, out_idx, out_data
    );

    modport slave (
        output start, act_data, w_data,
        input  busy, done, act_addr, w_addr, rd_en, out_valid, out_idx, out_data
    );
endinterface

// File: rtl/layer_mac_scheduler.sv
// Computes one fully connected layer by time-sharing a single MAC across all
// neuron/input products, then applies a clamp-and-quantise activation.
module layer_mac_scheduler #(
    parameter int N_IN  = 30,
    parameter int N_OUT = 16,
    parameter int DW    = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    layer_mac_scheduler_if.master bus,
    output logic [2:0]            dbg_state
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ACT, DONE} state_t;

    localparam logic [7:0]    K_LAST   = 8'(N_IN);
    localparam logic [7:0]    N_LAST   = 8'(N_OUT - 1);
    localparam logic [15:0]   W_STRIDE = 16'(N_IN + 1);
    localparam logic [DW-1:0] ACC_SAT  = DW'(8192);

    state_t        state, state_nxt;
    logic [7:0]    k;
    logic [7:0]    n;
    logic [15:0]   w_base;
    logic [DW-1:0] acc;
    logic [DW-1:0] prod;
    logic          prod_pend;
    logic          bias_pend;

    // Truncated DW-bit product; low bits are identical for signed and unsigned.
    assign prod      = bus.act_data * bus.w_data;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.rd_en     = 1'b0;
        bus.act_addr  = 8'd0;
        bus.w_addr    = 16'd0;
        bus.out_valid = 1'b0;
        bus.out_idx   = 8'd0;
        bus.out_data  = 8'd0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.busy     = 1'b1;
                bus.rd_en    = 1'b1;
                bus.w_addr   = w_base + 16'(k);
                bus.act_addr = (k == K_LAST) ? 8'd0 : k;
                if (k == K_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                bus.busy  = 1'b1;
                state_nxt = ACT;
            end
            ACT: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_idx   = n;
                // Exactly 8192 falls through to the bit slice and reads as zero.
                if (acc[DW-1])         bus.out_data = 8'd0;
                else if (acc > ACC_SAT) bus.out_data = 8'hFF;
                else                   bus.out_data = acc[12:5];
                state_nxt = (n == N_LAST) ? DONE : ISSUE;
            end
            DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pending flags mark that the memory data arriving this cycle answers
    // last cycle's product or bias request.
    always_ff @(posedge clk) begin
        if (reset) begin
            k         <= 8'd0;
            n         <= 8'd0;
            w_base    <= 16'd0;
            acc       <= '0;
            prod_pend <= 1'b0;
            bias_pend <= 1'b0;
        end else begin
            prod_pend <= (state == ISSUE) && (k != K_LAST);
            bias_pend <= (state == ISSUE) && (k == K_LAST);
            if (prod_pend)      acc <= acc + prod;
            else if (bias_pend) acc <= acc + bus.w_data;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        k      <= 8'd0;
                        n      <= 8'd0;
                        w_base <= 16'd0;
                        acc    <= '0;
                    end
                end
                ISSUE: begin
                    k <= (k == K_LAST) ? 8'd0 : k + 8'd1;
                end
                ACT: begin
                    if (n != N_LAST) begin
                        n      <= n + 8'd1;
                        w_base <= w_base + W_STRIDE;
                        acc    <= '0;
                        k      <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Bench for layer_mac_scheduler: a tiny 2x1 layer for directed arithmetic and
// timing cases, and a default 30x16 layer with random data against a sum model.
module tb_layer_mac_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_reset, b_reset;
    logic [2:0] s_dbg, b_dbg;

    layer_mac_scheduler_if #(.DW(24)) sif ();
    layer_mac_scheduler_if #(.DW(24)) bif ();

    layer_mac_scheduler #(.N_IN(2), .N_OUT(1), .DW(24)) u_small (
        .clk(clk), .reset(s_reset), .bus(sif.master), .dbg_state(s_dbg)
    );
    layer_mac_scheduler #(.N_IN(30), .N_OUT(16), .DW(24)) u_big (
        .clk(clk), .reset(b_reset), .bus(bif.master), .dbg_state(b_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] act_s [2];
    logic [23:0] w_s   [3];
    logic [23:0] act_b [30];
    logic [23:0] w_b   [496];
    logic [7:0]  exp_q [$];

    // Memories answer one cycle after the address.
    always @(posedge clk) begin
        sif.act_data <= (int'(sif.act_addr) < 2)   ? act_s[int'(sif.act_addr)] : 24'd0;
        sif.w_data   <= (int'(sif.w_addr)   < 3)   ? w_s[int'(sif.w_addr)]     : 24'd0;
        bif.act_data <= (int'(bif.act_addr) < 30)  ? act_b[int'(bif.act_addr)] : 24'd0;
        bif.w_data   <= (int'(bif.w_addr)   < 496) ? w_b[int'(bif.w_addr)]     : 24'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [23:0] v);
        return longint'(signed'(v));
    endfunction

    // Activation as stated: negative -> 0, above 8192 -> 0xFF, else bits 12:5.
    function automatic logic [7:0] act_ref(input logic [23:0] t);
        if (sx(t) < 0)    return 8'd0;
        if (sx(t) > 8192) return 8'hFF;
        return t[12:5];
    endfunction

    task automatic run_small(input logic [23:0] a0, input logic [23:0] a1,
                             input logic [23:0] w0, input logic [23:0] w1,
                             input logic [23:0] bias, input logic [7:0] exp_out,
                             input string tag);
        act_s[0] = a0; act_s[1] = a1;
        w_s[0] = w0; w_s[1] = w1; w_s[2] = bias;
        @(posedge clk); #1 sif.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            sif.start = 1'b0;
            chk({tag, "_busy"},  32'(sif.busy),  32'(c <= 6));
            chk({tag, "_rd_en"}, 32'(sif.rd_en), 32'(c <= 3));
            chk({tag, "_w_addr"}, 32'(sif.w_addr), (c <= 3) ? 32'(c - 1) : 32'd0);
            chk({tag, "_act_addr"}, 32'(sif.act_addr), (c <= 2) ? 32'(c - 1) : 32'd0);
            chk({tag, "_out_valid"}, 32'(sif.out_valid), 32'(c == 5));
            chk({tag, "_done"}, 32'(sif.done), 32'(c == 6));
            if (c == 5) begin
                chk({tag, "_out_idx"}, 32'(sif.out_idx), 32'd0);
                chk({tag, "_out_data"}, 32'(sif.out_data), 32'(exp_out));
            end
        end
    endtask

    task automatic randomize_big();
        for (int i = 0; i < 30; i++) act_b[i] = 24'($urandom_range(0, 31));
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 30; i++) w_b[j*31+i] = 24'(int'($urandom_range(0, 23)) - 8);
            w_b[j*31+30] = 24'(int'($urandom_range(0, 10000)) - 2000);
        end
    endtask

    task automatic run_big(input int restart_at, input int reset_at, input string tag);
        int  idx;
        int  strays;
        bit  seen_done;
        exp_q.delete();
        for (int j = 0; j < 16; j++) begin
            longint      s;
            logic [23:0] t;
            s = sx(w_b[j*31+30]);
            for (int i = 0; i < 30; i++) s += sx(act_b[i]) * sx(w_b[j*31+i]);
            t = s[23:0];
            exp_q.push_back(act_ref(t));
        end
        idx = 0; strays = 0; seen_done = 0;
        @(posedge clk); #1 bif.start = 1'b1;
        for (int c = 1; c <= 560; c++) begin
            @(posedge clk); #1;
            if (reset_at > 0 && c > reset_at) begin
                if (bif.out_valid || bif.done) strays++;
                if (c == reset_at + 1) chk({tag, "_busy_after_reset"}, 32'(bif.busy), 32'd0);
            end else begin
                if (bif.out_valid) begin
                    chk({tag, "_out_idx"}, 32'(bif.out_idx), 32'(idx));
                    chk({tag, "_out_cycle"}, 32'(c), 32'(33 * (idx + 1)));
                    if (exp_q.size() > 0) chk({tag, "_out_data"}, 32'(bif.out_data), 32'(exp_q.pop_front()));
                    else chk({tag, "_extra_out"}, 32'd1, 32'd0);
                    idx++;
                end
                if (bif.done) begin
                    chk({tag, "_done_cycle"}, 32'(c), 32'd529);
                    seen_done = 1;
                end
            end
            bif.start = (c == restart_at);
            b_reset   = (c == reset_at);
        end
        bif.start = 1'b0;
        b_reset   = 1'b0;
        if (reset_at > 0) begin
            chk({tag, "_strays"}, 32'(strays), 32'd0);
            chk({tag, "_n_out"}, 32'(idx), 32'd3);
        end else begin
            chk({tag, "_n_out"}, 32'(idx), 32'd16);
            chk({tag, "_seen_done"}, 32'(seen_done), 32'd1);
        end
    endtask

    initial begin
        s_reset = 1'b1; b_reset = 1'b1;
        sif.start = 1'b0; bif.start = 1'b0;
        for (int i = 0; i < 2; i++) act_s[i] = 24'd0;
        for (int i = 0; i < 3; i++) w_s[i] = 24'd0;
        for (int i = 0; i < 30; i++) act_b[i] = 24'd0;
        for (int i = 0; i < 496; i++) w_b[i] = 24'd0;
        repeat (3) @(posedge clk);
        #1 s_reset = 1'b0; b_reset = 1'b0;

        chk("rst_busy",      32'(sif.busy),      32'd0);
        chk("rst_done",      32'(sif.done),      32'd0);
        chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_rd_en",     32'(sif.rd_en),     32'd0);
        chk("rst_act_addr",  32'(sif.act_addr),  32'd0);
        chk("rst_w_addr",    32'(sif.w_addr),    32'd0);
        chk("rst_out_idx",   32'(sif.out_idx),   32'd0);
        chk("rst_out_data",  32'(sif.out_data),  32'd0);
        chk("rst_big_busy",  32'(bif.busy),      32'd0);
        chk("rst_big_rd_en", 32'(bif.rd_en),     32'd0);

        // Reset wins over a simultaneous start.
        @(posedge clk); #1 sif.start = 1'b1; s_reset = 1'b1;
        @(posedge clk); #1 sif.start = 1'b0; s_reset = 1'b0;
        chk("prio_busy",  32'(sif.busy),  32'd0);
        chk("prio_rd_en", 32'(sif.rd_en), 32'd0);

        run_small(24'd10, 24'd20, 24'd3, 24'd4, 24'd32, 8'd4, "sum142");
        run_small(24'd1, 24'd1, 24'hFFFFFB, 24'hFFFFFB, 24'd0, 8'd0, "neg");
        run_small(24'd1, 24'd1, 24'd0, 24'd0, 24'd8193, 8'hFF, "sat8193");
        run_small(24'd1, 24'd1, 24'd0, 24'd0, 24'd8192, 8'h00, "edge8192");
        run_small(24'd1, 24'd1, 24'd0, 24'd0, 24'd8191, 8'hFF, "under8191");
        run_small(24'h7FFFFF, 24'd0, 24'd2, 24'd0, 24'd0, 8'd0, "wrap");
        run_small(24'd31, 24'd7, 24'd9, 24'd100, 24'd700, 8'd52, "mixed");

        randomize_big();
        run_big(0, 0, "base");
        run_big(10, 0, "restart");
        run_big(0, 110, "midreset");
        run_big(0, 0, "after_reset");
        randomize_big();
        run_big(0, 0, "rand2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_mac_scheduler.md
LAYER_MAC_SCHEDULER -- requirements
Module: layer_mac_scheduler

Interface
REQ-001 Parameter N_IN, default 30, inputs per neuron (2..255).
REQ-002 Parameter N_OUT, default 16, neurons per layer (1..255).
REQ-003 Parameter DW, default 24, datapath width.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 start  input  1  one-cycle request to compute the whole layer.
REQ-007 busy  output  1  high from accepted start until the done cycle, inclusive.
REQ-008 done  output  1  one-cycle pulse after the last neuron result is written.
REQ-009 act_addr  output  8  activation memory read address (input index).
REQ-010 act_data  input  DW  activation read data, valid 1 cycle after act_addr.
REQ-011 w_addr  output  16  weight memory read address.
REQ-012 w_data  input  DW  weight/bias read data, valid 1 cycle after w_addr.
REQ-013 rd_en  output  1  high in every cycle that act_addr/w_addr carry a live request.
REQ-014 out_valid  output  1  one-cycle write strobe for a neuron result.
REQ-015 out_idx  output  8  neuron index of the result.
REQ-016 out_data  output  8  activated, quantised neuron result.

Function
REQ-017 The block SHALL time-share one DW-bit multiply-accumulate unit across all N_OUT x N_IN products of the layer.
REQ-018 FSM states SHALL be IDLE, ISSUE, DRAIN, ACT, DONE; reset enters IDLE.
REQ-019 IDLE->ISSUE on start=1; neuron index n=0, input index i=0; busy rises the next cycle.
REQ-020 start while not in IDLE SHALL be ignored (no restart, no queuing).
REQ-021 ISSUE lasts N_IN+1 cycles; cycle k<N_IN drives act_addr=k, w_addr=n*(N_IN+1)+k; cycle k=N_IN drives w_addr=n*(N_IN+1)+N_IN (bias), act_addr=0; rd_en=1 throughout.
REQ-022 Accumulator cleared on ISSUE entry; each cycle after a product request, acc += act_data*w_data; after the bias request, acc += w_data (not multiplied).
REQ-023 Products and sums SHALL be two's complement, truncated to DW bits (mod 2^DW wrap, no saturation in accumulation).
REQ-024 DRAIN lasts 1 cycle (consumes the bias data); rd_en=0.
REQ-025 ACT lasts 1 cycle: out_valid=1, out_idx=n, out_data = 0 if acc[DW-1]=1; else 8'hFF if acc>8192; else acc[12:5].
REQ-026 acc=8192 exactly SHALL yield out_data=acc[12:5]=8'h00 (boundary retained as specified).
REQ-027 ACT->ISSUE with n+1 if n<N_OUT-1, else ACT->DONE.
REQ-028 DONE lasts 1 cycle: done=1, busy=1; then IDLE, busy=0.
REQ-029 Per-neuron latency SHALL be N_IN+3 cycles; start-to-done = N_OUT*(N_IN+3)+1 cycles (start cycle to done cycle, exclusive of start).
REQ-030 out_valid, done SHALL be low in all other states; addresses SHALL be 0 when rd_en=0.
REQ-031 N_OUT=1 SHALL go ISSUE->DRAIN->ACT->DONE once.

Reset
REQ-032 reset SHALL force IDLE, busy=0, done=0, out_valid=0, rd_en=0, out_idx=0, out_data=0, act_addr=0, w_addr=0, acc=0 on the next edge.
REQ-033 reset mid-layer SHALL abandon the computation with no further out_valid or done; the next start begins at neuron 0.
REQ-034 reset SHALL take priority over start in the same cycle.

Verification
REQ-035 N_IN=2, N_OUT=1, act={10,20}, weights {3,4}, bias 32: sum=142 -> out_data=4 (142>>5), done 6 cycles after start.
REQ-036 Negative sum: act={1,1}, weights {-5,-5}, bias 0 -> out_data=0; sum=8193 -> 8'hFF; sum=8192 -> 8'h00; sum=8191 -> 8'hFF (bits 12:5).
REQ-037 Default N_IN=30, N_OUT=16 random data vs golden model: 16 out_valid pulses, out_idx 0..15 in order, spaced 33 cycles, done at cycle 529.
REQ-038 start pulsed again at cycle 10 of a run -> ignored; result stream identical to single-start run.
REQ-039 reset asserted during neuron 3 -> no further out_valid/done; busy=0 next cycle; new start reproduces full correct stream.
REQ-040 Wrap check: act=0x7FFFFF, weight 2, bias 0 -> acc=0xFFFFFE (negative) -> out_data=0.
